// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state encoding and grant encode helpers for mux4_rr_arbiter
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // One-hot (or all-zero) grant to binary mux select
    function automatic logic [SEL_W-1:0] onehot2bin(input logic [N_REQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    // Binary index to one-hot grant
    function automatic logic [N_REQ-1:0] bin2onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// rtl/mux4_rr_arbiter_rr_pick.sv - rr_pick: first set request bit at or after start, modulo 4
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        found  = 1'b0;
        idx    = start;
        w_cand = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = start + SEL_W'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux; optional hold timeout under ARB_TIMEOUT_EN
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data
);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_grant;

    logic [SEL_W-1:0] w_cur;
    logic [N_REQ-1:0] w_pick_req;
    logic [SEL_W-1:0] w_pick_start;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_release;

    assign w_cur = onehot2bin(r_grant);

    // While busy the current owner is excluded and the search starts just past it
    assign w_pick_req   = (r_state == ST_BUSY) ? (req & ~r_grant) : req;
    assign w_pick_start = (r_state == ST_BUSY) ? (w_cur + SEL_W'(1)) : r_ptr;

    rr_pick u_rr_pick (
        .req   (w_pick_req),
        .start (w_pick_start),
        .found (w_found),
        .idx   (w_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              w_hold_max;

    assign w_hold_max = (r_hold == HOLD_W'(HOLD_MAX - 1));
    assign w_release  = !req[w_cur] || (w_hold_max && w_found);

    // Hold counter: clears on each new grant, counts busy cycles, saturates at HOLD_MAX-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == ST_IDLE || w_release) begin
            r_hold <= '0;
        end else if (!w_hold_max) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    logic w_unused_hold_max;

    assign w_unused_hold_max = (HOLD_MAX > 0);
    assign w_release         = !req[w_cur];
`endif

    // Arbitration FSM: grant on request, hand over without a bubble on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= bin2onehot(w_idx);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_ptr <= w_cur + SEL_W'(1);
                        if (w_found) begin
                            r_grant <= bin2onehot(w_idx);
                        end else begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign sel       = onehot2bin(r_grant);
    assign out_valid = |r_grant;

    // Output mux on the registered select, forced to zero when idle
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (sel)
                2'd0:    out_data = din[0*DATA_W +: DATA_W];
                2'd1:    out_data = din[1*DATA_W +: DATA_W];
                2'd2:    out_data = din[2*DATA_W +: DATA_W];
                default: out_data = din[3*DATA_W +: DATA_W];
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] din;
    logic [3:0]          grant;
    logic [1:0]          sel;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;

    int n_checks;
    int n_fail;

    mux4_rr_arbiter #(
        .DATA_W   (DATA_W),
        .HOLD_MAX (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Grant must be one-hot or zero on every cycle
    always @(negedge clk) begin
        check_eq("grant_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        din      = {8'h44, 8'hA5, 8'h22, 8'h11};

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", {28'b0, grant}, 32'h0);
        check_eq("rst_sel", {30'b0, sel}, 32'h0);
        check_eq("rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_data", {24'b0, out_data}, 32'h0);
        rst = 1'b0;

        // Single requester, one-cycle latency, then release to idle
        req = 4'b0100;
        tick();
        check_eq("single_grant", {28'b0, grant}, 32'h4);
        check_eq("single_sel", {30'b0, sel}, 32'd2);
        check_eq("single_valid", {31'b0, out_valid}, 32'h1);
        check_eq("single_data", {24'b0, out_data}, 32'hA5);
        req = 4'b0000;
        tick();
        check_eq("drop_valid", {31'b0, out_valid}, 32'h0);
        check_eq("drop_data", {24'b0, out_data}, 32'h0);

        // All four requesting: order 0,1,2,3,0 with no idle cycle
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("rr_grant_first", {28'b0, grant}, 32'(1 << (k % 4)));
            check_eq("rr_valid", {31'b0, out_valid}, 32'h1);
            tick();
            check_eq("rr_grant_hold", {28'b0, grant}, 32'(1 << (k % 4)));
            req = 4'b1111 & ~4'(1 << (k % 4));
            tick();
            req = 4'b1111;
        end
        check_eq("rr_after_wrap", {28'b0, grant}, 32'h2);
        req = 4'b0000;
        tick();
        check_eq("rr_idle", {28'b0, grant}, 32'h0);

        // Wrap-around from requester 3 with 0 and 1 pending
        req = 4'b1000;
        tick();
        check_eq("wrap_g3", {28'b0, grant}, 32'h8);
        check_eq("wrap_g3_data", {24'b0, out_data}, 32'h44);
        req = 4'b0011;
        tick();
        check_eq("wrap_g0", {28'b0, grant}, 32'h1);
        check_eq("wrap_g0_data", {24'b0, out_data}, 32'h11);
        tick();
        check_eq("wrap_g0_hold", {28'b0, grant}, 32'h1);
        req = 4'b0010;
        tick();
        check_eq("wrap_g1", {28'b0, grant}, 32'h2);

        // Asynchronous reset mid-grant, then search restarts at 0
        rst = 1'b1;
        #1;
        check_eq("async_grant", {28'b0, grant}, 32'h0);
        check_eq("async_sel", {30'b0, sel}, 32'h0);
        check_eq("async_valid", {31'b0, out_valid}, 32'h0);
        check_eq("async_data", {24'b0, out_data}, 32'h0);
        #1;
        rst = 1'b0;
        req = 4'b1000;
        tick();
        check_eq("post_rst_g3", {28'b0, grant}, 32'h8);
        req = 4'b0000;
        tick();

`ifdef ARB_TIMEOUT_EN
        // req[0] stuck, req[1] joins at cycle 2: forced move after 8 cycles on 0
        pulse_reset();
        req = 4'b0001;
        tick();
        check_eq("to_g0_start", {28'b0, grant}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            if (i == 2) req = 4'b0011;
            tick();
            check_eq("to_g0_held", {28'b0, grant}, 32'h1);
        end
        tick();
        check_eq("to_forced_g1", {28'b0, grant}, 32'h2);
        check_eq("to_forced_data", {24'b0, out_data}, 32'h22);

        // Nobody else waiting: counter saturates, grant stays
        pulse_reset();
        req = 4'b0001;
        for (int i = 0; i < 22; i++) begin
            tick();
            check_eq("to_sat_g0", {28'b0, grant}, 32'h1);
        end
`else
        // Without timeout the owner keeps the grant until it drops req
        pulse_reset();
        req = 4'b0001;
        tick();
        check_eq("nto_g0_start", {28'b0, grant}, 32'h1);
        for (int i = 1; i < 20; i++) begin
            if (i == 2) req = 4'b0011;
            tick();
            check_eq("nto_g0_held", {28'b0, grant}, 32'h1);
        end
        req = 4'b0010;
        tick();
        check_eq("nto_g1", {28'b0, grant}, 32'h2);
        check_eq("nto_g1_sel", {30'b0, sel}, 32'd1);
        check_eq("nto_g1_data", {24'b0, out_data}, 32'h22);
`endif

        req = 4'b0000;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
